// File: rtl/ofifo_col.sv
// ofifo_col: output FIFO behind the MAC row array.
// Each column has its own circular buffer because the columns drain skewed in
// time. Reads pop one aligned row across all columns, and the head row is
// shown on out with first-word fall-through.
// Optional build macro OFIFO_OVF_FLAG_EN adds a sticky o_ovf flag. The flag
// records any write that was dropped because its column was full.
module ofifo_col #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
`ifdef OFIFO_OVF_FLAG_EN
  output logic                   o_ovf,
`endif
  output logic                   o_ready
);

  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);

  logic [col-1:0] non_empty;
  logic [col-1:0] is_full;
  logic           pop;

  // A row pop only happens when every column has data, so rd on an
  // incomplete row is ignored rather than underflowing any column.
  assign pop     = rd & o_valid;
  assign o_valid = &non_empty;
  assign o_full  = |is_full;
  assign o_ready = ~o_full;

`ifdef OFIFO_OVF_FLAG_EN
  logic [col-1:0] drop;
`endif

  for (genvar i = 0; i < col; i++) begin : g_col
    logic [psum_bw-1:0] mem [depth];
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic [CW-1:0]      cnt;
    logic               accept;

    // A full column still accepts a write when the same cycle pops, because
    // the pop frees the slot that the write needs.
    assign accept = wr[i] & ((cnt != CW'(depth)) | pop);

    // Storage is never cleared. Writes are held off during reset so that
    // the post-reset head at pointer 0 stays deterministic.
    always_ff @(posedge clk) begin
      if (reset && accept) begin
        mem[wptr] <= in[i*psum_bw +: psum_bw];
      end
    end

    // Pointer and occupancy bookkeeping for this column.
    always_ff @(posedge clk) begin
      if (!reset) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (accept) begin
          wptr <= wptr + 1'b1;
        end
        if (pop) begin
          rptr <= rptr + 1'b1;
        end
        case ({accept, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    assign out[i*psum_bw +: psum_bw] = mem[rptr];
    assign non_empty[i]              = (cnt != '0);
    assign is_full[i]                = (cnt == CW'(depth));

`ifdef OFIFO_OVF_FLAG_EN
    assign drop[i] = wr[i] & is_full[i] & ~pop;
`endif
  end

`ifdef OFIFO_OVF_FLAG_EN
  // Sticky overflow flag. Once a dropped write has happened, only reset
  // clears the flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_ovf <= 1'b0;
    end else if (|drop) begin
      o_ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ofifo_col.sv
// tb_ofifo_col: directed self-checking bench for ofifo_col (8 x 16-bit, depth 64).
// The o_ovf scenario is compiled only when OFIFO_OVF_FLAG_EN is defined.
module tb_ofifo_col;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DEP = 64;

  logic              clk;
  logic              reset;
  logic [BW*COL-1:0] in_bus;
  logic [COL-1:0]    wr;
  logic              rd;
  logic [BW*COL-1:0] out_bus;
  logic              o_valid;
  logic              o_full;
  logic              o_ready;
`ifdef OFIFO_OVF_FLAG_EN
  logic              o_ovf;
`endif

  int n_compared;
  int n_mismatched;

  ofifo_col #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in_bus),
    .wr      (wr),
    .rd      (rd),
    .out     (out_bus),
    .o_valid (o_valid),
    .o_full  (o_full),
`ifdef OFIFO_OVF_FLAG_EN
    .o_ovf   (o_ovf),
`endif
    .o_ready (o_ready)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Build a row with the same value in every column.
  function automatic logic [BW*COL-1:0] rep(input logic [BW-1:0] v);
    logic [BW*COL-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = v;
    return r;
  endfunction

  // Reset is held for 2 cycles while wr and rd are active. Reset must win,
  // and no data may be captured.
  task automatic test_reset();
    reset  = 1'b0;
    wr     = 8'hFF;
    rd     = 1'b1;
    in_bus = rep(16'hDEAD);
    tick();
    tick();
    n_compared++;
    if (o_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_valid actual=%b required=0", o_valid);
    end
    n_compared++;
    if (o_full !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_full actual=%b required=0", o_full);
    end
    n_compared++;
    if (o_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_ready actual=%b required=1", o_ready);
    end
    reset = 1'b1;
    wr    = '0;
    rd    = 1'b0;
    tick();
    n_compared++;
    if (o_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_idle_valid actual=%b required=0", o_valid);
    end
  endtask

  // Skewed fill: column c is written in cycle c. The row becomes valid
  // only after column 7 is written.
  task automatic test_skewed_fill();
    logic [BW*COL-1:0] exp_row;
    in_bus = '0;
    for (int c = 0; c < COL; c++) begin
      wr = '0;
      wr[c] = 1'b1;
      in_bus[c*BW +: BW] = 16'h0100 + 16'(c);
      exp_row[c*BW +: BW] = 16'h0100 + 16'(c);
      tick();
      n_compared++;
      if (o_valid !== 1'(c == COL-1)) begin
        n_mismatched++;
        $display("[TB] FAIL skew_valid_col%0d actual=%b required=%b", c, o_valid, c == COL-1);
      end
    end
    wr = '0;
    n_compared++;
    if (out_bus !== exp_row) begin
      n_mismatched++;
      $display("[TB] FAIL skew_row actual=%h required=%h", out_bus, exp_row);
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_compared++;
    if (o_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL skew_after_pop_valid actual=%b required=0", o_valid);
    end
  endtask

  // Fill to depth, then drain. The pointers start at 1 after the previous
  // test, so the drain runs through the wrap from 63 to 0.
  task automatic test_full_wrap();
    for (int k = 0; k < DEP; k++) begin
      wr = 8'hFF;
      in_bus = rep(16'(k));
      tick();
      n_compared++;
      if (o_full !== 1'(k == DEP-1) || o_ready !== 1'(k != DEP-1)) begin
        n_mismatched++;
        $display("[TB] FAIL fill_full_k%0d actual full=%b ready=%b required full=%b ready=%b",
                 k, o_full, o_ready, k == DEP-1, k != DEP-1);
      end
    end
    wr = '0;
    for (int k = 0; k < DEP; k++) begin
      n_compared++;
      if (out_bus !== rep(16'(k)) || o_valid !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL drain_k%0d actual=%h valid=%b required=%h valid=1",
                 k, out_bus, o_valid, rep(16'(k)));
      end
      rd = 1'b1;
      tick();
      rd = 1'b0;
    end
    n_compared++;
    if (o_valid !== 1'b0 || o_full !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL drain_empty actual valid=%b full=%b required 0/0", o_valid, o_full);
    end
  endtask

  // When a full FIFO sees wr and rd together, the write is accepted and the
  // FIFO stays full.
  task automatic test_full_simul();
    for (int k = 0; k < DEP; k++) begin
      wr = 8'hFF;
      in_bus = rep(16'(k));
      tick();
    end
    wr = 8'hFF;
    rd = 1'b1;
    in_bus = rep(16'hAAAA);
    tick();
    wr = '0;
    rd = 1'b0;
    n_compared++;
    if (o_full !== 1'b1 || out_bus !== rep(16'd1)) begin
      n_mismatched++;
      $display("[TB] FAIL full_simul actual full=%b head=%h required full=1 head=%h",
               o_full, out_bus, rep(16'd1));
    end
    for (int k = 1; k < DEP; k++) begin
      rd = 1'b1;
      tick();
    end
    rd = 1'b0;
    n_compared++;
    if (out_bus !== rep(16'hAAAA) || o_valid !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL full_simul_last actual=%h valid=%b required=%h valid=1",
               out_bus, o_valid, rep(16'hAAAA));
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_compared++;
    if (o_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL full_simul_empty actual=%b required=0", o_valid);
    end
  endtask

`ifdef OFIFO_OVF_FLAG_EN
  // A write to a full column without a pop is dropped and sets the sticky
  // o_ovf flag. Only reset clears it.
  task automatic test_ovf();
    for (int k = 0; k < DEP; k++) begin
      wr = 8'h08;
      in_bus = rep(16'(k));
      tick();
    end
    n_compared++;
    if (o_ovf !== 1'b0 || o_full !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL ovf_pre actual ovf=%b full=%b required 0/1", o_ovf, o_full);
    end
    wr = 8'h08;
    in_bus = rep(16'hBEEF);
    tick();
    wr = '0;
    n_compared++;
    if (o_ovf !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL ovf_set actual=%b required=1", o_ovf);
    end
    tick();
    tick();
    n_compared++;
    if (o_ovf !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL ovf_sticky actual=%b required=1", o_ovf);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_compared++;
    if (o_ovf !== 1'b0 || o_full !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL ovf_clear actual ovf=%b full=%b required 0/0", o_ovf, o_full);
    end
  endtask
`endif

  // Reset with 10 entries stored discards them. Afterwards only new data
  // appears. This also covers a simultaneous read and write at cnt==1.
  task automatic test_reset_midop();
    for (int k = 0; k < 10; k++) begin
      wr = 8'hFF;
      in_bus = rep(16'h0050 + 16'(k));
      tick();
    end
    wr = '0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_compared++;
    if (o_valid !== 1'b0 || o_full !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL midop_reset actual valid=%b full=%b required 0/0", o_valid, o_full);
    end
    wr = 8'hFF;
    in_bus = rep(16'h1234);
    tick();
    wr = '0;
    n_compared++;
    if (o_valid !== 1'b1 || out_bus !== rep(16'h1234)) begin
      n_mismatched++;
      $display("[TB] FAIL midop_new actual=%h valid=%b required=%h valid=1",
               out_bus, o_valid, rep(16'h1234));
    end
    wr = 8'hFF;
    rd = 1'b1;
    in_bus = rep(16'h5678);
    tick();
    wr = '0;
    rd = 1'b0;
    n_compared++;
    if (o_valid !== 1'b1 || out_bus !== rep(16'h5678)) begin
      n_mismatched++;
      $display("[TB] FAIL cnt1_rw actual=%h valid=%b required=%h valid=1",
               out_bus, o_valid, rep(16'h5678));
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_compared++;
    if (o_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL cnt1_drain actual=%b required=0", o_valid);
    end
  endtask

  // Run the scenarios in sequence, then print the summary line.
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset  = 1'b0;
    wr     = '0;
    rd     = 1'b0;
    in_bus = '0;
    #1;
    test_reset();
    test_skewed_fill();
    test_full_wrap();
    test_full_simul();
`ifdef OFIFO_OVF_FLAG_EN
    test_ovf();
`endif
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/ofifo_col.md
Name: ofifo_col

Overview:
- Output FIFO directly downstream of the MAC row array. Captures each column's psum when that column's valid bit fires.
- Columns drain skewed in time, so each column has its own circular buffer.
- Presents one aligned row of psums (all columns) to the SFU/memory-write stage.
- First-word fall-through: the head row is visible on out whenever o_valid=1.

Parameters:
- col, 8, number of columns (matches array width).
- psum_bw, 16, width of one psum entry.
- depth, 64, entries per column buffer; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low; reset==0 at a rising edge clears all state.
- in  input  psum_bw*col  psum bus from array; column i at in[i*psum_bw +: psum_bw].
- wr  input  col  per-column write strobe (array valid); wr[i] writes column i.
- rd  input  1  pop one aligned row from all columns.
- out  output  psum_bw*col  head entry of each column; column i at out[i*psum_bw +: psum_bw].
- o_valid  output  1  all columns non-empty (an aligned row is available).
- o_full  output  1  at least one column holds depth entries.
- o_ready  output  1  equals ~o_full; upstream may issue execute.

Behaviour:
- Reset (reset==0 at posedge):
  - All read/write pointers and per-column counts go to 0.
  - o_valid=0, o_full=0, o_ready=1.
  - out is don't-care, but deterministic: storage is not cleared and out shows the entry at pointer 0.
  - Reset overrides rd and wr in the same cycle.
  - Reset mid-operation discards all stored data.
- Per-column state:
  - wptr and rptr, each log2(depth) bits, wrapping modulo depth.
  - cnt, $clog2(depth+1) bits, range 0..depth.
- Pop: pop = rd & o_valid, and applies to all columns together. rd while o_valid=0 is ignored (no pointer change, no underflow).
- Write acceptance for column i: wr[i] & (cnt[i] < depth | pop).
  - A write to a full column that coincides with a pop is accepted.
  - A write to a full column without a pop is dropped; wptr and cnt are unchanged.
- Accepted write:
  - mem_i[wptr_i] <= in column i.
  - wptr_i increments.
- Count update per column:
  - write and pop together: cnt unchanged.
  - write only: cnt+1.
  - pop only: cnt-1.
- Pop updates: every rptr_i increments.
- Outputs, combinational from state:
  - out column i = mem_i[rptr_i].
  - o_valid = AND over all cnt_i != 0.
  - o_full = OR over all cnt_i == depth.
- Latency:
  - A write at posedge t is visible on out/o_valid after posedge t (one-cycle write-to-read).
  - Pop takes effect at the posedge where rd & o_valid is sampled. The next head is shown after that edge.
- Wrap-around: pointers roll from depth-1 to 0 with no bubble. Capacity is a full depth entries per column.
- Simultaneous read and write on a column with cnt==1: the pop reads the old head, and the new entry becomes the head. o_valid stays 1 if all other columns still hold at least one entry.
- Columns are fully independent apart from the shared pop. Skewed arrival is expected: column i's valid lags column i-1 by 1 cycle.

Optional Feature:
- Macro: OFIFO_OVF_FLAG_EN.
- Defined:
  - Adds output port o_ovf, 1 bit.
  - o_ovf is sticky: it is set on the posedge after any dropped write (wr[i] with cnt[i]==depth and no pop).
  - It is cleared only by reset. Reset value is 0.
- Undefined:
  - No o_ovf port and no register.
  - Dropped writes are silent. All other behaviour is identical.

Test Plan:
- Reset then idle, with reset=0 for 2 cycles and wr=8'hFF, rd=1 → o_valid=0, o_full=0, o_ready=1; no counts change.
- Skewed fill: wr[i] pulses at cycle i with in column i=16'h0100+i, then rd=1 once o_valid=1 → o_valid rises only after column 7 is written; out=all 8 values; o_valid=0 after the pop.
- Fill all columns with 64 entries of incrementing value k → o_full=1 and o_ready=0 after the 64th write. 64 pops return 0..63 in order per column, covering pointer wrap.
- Full plus simultaneous wr and rd on every column → write accepted; cnt stays 64; o_full stays 1; the next head is value 1.
- With OFIFO_OVF_FLAG_EN, write column 3 when full with rd=0 → write dropped; o_ovf=1 next cycle and stays 1 until reset=0.
- Reset asserted with 10 entries per column → o_valid=0 and cnt=0 next cycle. A subsequent write/pop returns only the new data.
